timer_sched: RTL and testbench

TIMER_SCHED -- requirements
Module: timer_sched

---
 rtl/timer_sched.sv | 146 ++++++++++++++
 tb/tb_timer_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// Round-robin scheduler that lends one shared free-running timer to NREQ requesters,
// one job at a time, and pulses done when the granted requester's duration has elapsed.
module timer_sched #(
    parameter int NREQ = 4,
    parameter int TW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*TW-1:0] dur,
    input  logic [TW-1:0]      t_out,
    input  logic               t_valid,
    output logic               t_en,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic               err,
    output logic [1:0]         dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [IW-1:0] last_q;
    logic [IW-1:0] win_q;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand_idx;
    logic          win_found;
    logic [TW-1:0] win_dur;
    logic [TW-1:0] dur_q;
    logic [TW-1:0] start_q;
    logic [TW-1:0] elapsed;
    logic [TW-1:0] elapsed_next;
    logic          t_en_d;
    logic          abort;
    int            cand;

    // Modular subtraction keeps elapsed correct across the timer wrapping to zero.
    assign elapsed      = t_out - start_q;
    assign elapsed_next = elapsed + {{(TW-1){1'b0}}, t_en};
    assign abort        = !req[win_q];
    assign busy         = (state != IDLE);
    assign dbg_state    = state;

    // Search starts one past the last granted index so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(last_q) + k) % NREQ;
            cand_idx = IW'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        win_dur = dur[win_idx*TW +: TW];
    end

    // t_en is registered: the value for the next cycle is predicted from the
    // elapsed count that the timer will show once this cycle's enable has counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            t_en    <= 1'b0;
            t_en_d  <= 1'b0;
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
            dur_q   <= '0;
            start_q <= '0;
            win_q   <= '0;
            last_q  <= IW'(NREQ - 1);
        end else begin
            t_en_d <= t_en;
            if (t_en_d != t_valid) begin
                err <= 1'b1;
            end
            done <= '0;
            case (state)
                IDLE: begin
                    t_en <= 1'b0;
                    if (win_found) begin
                        gnt    <= NREQ'(1) << win_idx;
                        win_q  <= win_idx;
                        last_q <= win_idx;
                        dur_q  <= win_dur;
                        t_en   <= (win_dur != '0);
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    start_q <= t_out;
                    if (abort) begin
                        state <= IDLE;
                        gnt   <= '0;
                        t_en  <= 1'b0;
                    end else if (dur_q == '0) begin
                        state <= DONE;
                        done  <= gnt;
                        t_en  <= 1'b0;
                    end else begin
                        state <= RUN;
                        t_en  <= (dur_q != TW'(1));
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        gnt   <= '0;
                        t_en  <= 1'b0;
                    end else if (elapsed == dur_q) begin
                        state <= DONE;
                        done  <= gnt;
                        t_en  <= 1'b0;
                    end else begin
                        t_en <= (elapsed_next != dur_q);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gnt   <= '0;
                    t_en  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    t_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: models the shared timer, drives jobs and checks grants,
// done pulses, timing, abort, round-robin order, err and reset behaviour.
module tb_timer_sched;

    localparam int NREQ = 4;
    localparam int TW   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*TW-1:0] dur;
    logic [TW-1:0]      t_out;
    logic               t_valid;
    logic               t_en;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic               err;
    logic [1:0]         dbg_state;

    int          n_vec   = 0;
    int          n_err   = 0;
    int          cyc     = 0;
    int          en_cnt  = 0;
    int          t0      = 0;
    logic        force_lo = 1'b0;
    logic        en_s;
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];

    timer_sched #(.NREQ(NREQ), .TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .dur       (dur),
        .t_out     (t_out),
        .t_valid   (t_valid),
        .t_en      (t_en),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: shared timer counts on enabled cycles, t_valid echoes last t_en.
    task automatic tick();
        logic [31:0] e;
        int          ec;
        @(negedge clk);
        en_s = t_en;
        @(posedge clk);
        #1;
        cyc++;
        if (en_s) en_cnt++;
        t_out   = t_out + {{(TW-1){1'b0}}, en_s};
        t_valid = force_lo ? 1'b0 : en_s;
        if (done !== '0) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("done_vec", 32'(done), e);
                check("done_cycle", 32'(cyc), 32'(ec));
            end
        end
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done !== '0) seen = 1'b1;
        end
        check("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic run_job(input int idx, input logic [TW-1:0] dval,
                           input logic [TW-1:0] start_t, input string tag);
        logic [TW-1:0] t_end;
        t_out = start_t;
        dur   = '0;
        dur[idx*TW +: TW] = dval;
        req      = '0;
        req[idx] = 1'b1;
        en_cnt   = 0;
        exp_q.push_back(32'd1 << idx);
        exp_cyc_q.push_back(cyc + 2 + int'(dval));
        tick();
        check({tag, "_gnt"}, 32'(gnt), 32'd1 << idx);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        dur = '1;
        wait_done(int'(dval) + 8);
        t_end = start_t + dval;
        check({tag, "_tout"}, 32'(t_out), 32'(t_end));
        check({tag, "_en_cycles"}, 32'(en_cnt), 32'(dval));
        req = '0;
        tick();
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_idle_ten"}, 32'(t_en), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        dur     = '0;
        t_out   = '0;
        t_valid = 1'b0;
        tick();
        tick();
        check("rst_ten", 32'(t_en), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        tick();

        run_job(0, 16'd5, 16'd100, "single");
        run_job(3, 16'd4, 16'hFFFE, "wrap");
        run_job(2, 16'd0, 16'h0040, "zero");

        // Round-robin with all four requesting; restart from reset so index 0 leads.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        req = '1;
        dur = {NREQ{16'd1}};
        t0  = cyc;
        for (int g = 0; g < 5; g++) begin
            exp_q.push_back(32'd1 << (g % 4));
            exp_cyc_q.push_back(t0 + 3 + 4 * g);
        end
        for (int g = 0; g < 5; g++) begin
            wait_done(12);
            check("rr_gnt", 32'(gnt), 32'd1 << (g % 4));
        end
        req = '0;
        tick();
        check("rr_idle", 32'(busy), 32'd0);

        // Abort: requester 1 drops req during RUN.
        req = 4'b0010;
        dur = '0;
        dur[TW +: TW] = 16'd10;
        tick();
        check("abort_gnt", 32'(gnt), 32'd2);
        tick();
        tick();
        tick();
        req = '0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_gnt_clr", 32'(gnt), 32'd0);
        check("abort_ten", 32'(t_en), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        tick();
        tick();
        req = 4'b0011;
        dur = {NREQ{16'd1}};
        exp_q.push_back(32'd1);
        exp_cyc_q.push_back(cyc + 3);
        tick();
        check("post_abort_gnt", 32'(gnt), 32'd1);
        wait_done(8);
        req = '0;
        tick();
        check("post_abort_idle", 32'(busy), 32'd0);

        // Enable/echo mismatch makes err sticky.
        check("err_clean", 32'(err), 32'd0);
        req = 4'b0001;
        dur = '0;
        dur[0 +: TW] = 16'd20;
        tick();
        tick();
        check("err_ten_on", 32'(t_en), 32'd1);
        force_lo = 1'b1;
        tick();
        force_lo = 1'b0;
        tick();
        tick();
        check("err_set", 32'(err), 32'd1);
        tick();
        check("err_sticky", 32'(err), 32'd1);
        check("mid_run_busy", 32'(busy), 32'd1);

        // Asynchronous reset in the middle of RUN.
        #2;
        rst = 1'b1;
        #1;
        check("arst_ten", 32'(t_en), 32'd0);
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        tick();
        rst = 1'b0;
        req = '0;
        tick();
        req = 4'b1001;
        dur = {NREQ{16'd1}};
        exp_q.push_back(32'd1);
        exp_cyc_q.push_back(cyc + 3);
        tick();
        check("arst_rr_gnt", 32'(gnt), 32'd1);
        wait_done(8);
        req = '0;
        tick();
        check("final_idle", 32'(busy), 32'd0);
        check("final_err", 32'(err), 32'd0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
